life_gen_controller: RTL and testbench



---
 rtl/life_pkg.sv | 27 ++
 rtl/life_nbr_addr.sv | 39 +++
 rtl/life_gen_controller.sv | 196 +++++++++++++++++++
 tb/tb_life_gen_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared constants and types for the Game-of-Life generation
// sequencer and its neighbour-address helper.
//   GRID_W / GRID_H    default grid size (x 0..159, y 0..119)
//   X_W / Y_W          coordinate widths
//   INIT_COL           column seeded alive by a load command
//   ALIVE/DEAD_COLOUR  VGA colours for live / dead cells
//   gen_state_e        sequencer states
package life_pkg;

  localparam int GRID_W   = 160;
  localparam int GRID_H   = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int INIT_COL = 50;

  localparam logic [2:0] ALIVE_COLOUR = 3'b111;
  localparam logic [2:0] DEAD_COLOUR  = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COMPUTE,
    S_SWAP,
    S_DRAW
  } gen_state_e;

endpackage

// File: rtl/life_nbr_addr.sv
// life_nbr_addr: combinational toroidal neighbour address.
//   cx, cy  centre cell
//   idx     offset index 0..8, dy-major then dx: idx = (dy+1)*3 + (dx+1);
//           idx 4 is the centre itself, values above 8 return the centre
//   nx, ny  wrapped neighbour coordinates
module life_nbr_addr
  import life_pkg::*;
#(
  parameter int COLS = GRID_W,
  parameter int ROWS = GRID_H
) (
  input  logic [X_W-1:0] cx,
  input  logic [Y_W-1:0] cy,
  input  logic [3:0]     idx,
  output logic [X_W-1:0] nx,
  output logic [Y_W-1:0] ny
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  always_comb begin
    nx = cx;
    ny = cy;
    // dx column of the 3x3 window
    case (idx)
      4'd0, 4'd3, 4'd6: nx = (cx == '0) ? X_LAST : cx - 1'b1;
      4'd2, 4'd5, 4'd8: nx = (cx == X_LAST) ? '0 : cx + 1'b1;
      default: ;
    endcase
    // dy row of the 3x3 window
    case (idx)
      4'd0, 4'd1, 4'd2: ny = (cy == '0) ? Y_LAST : cy - 1'b1;
      4'd6, 4'd7, 4'd8: ny = (cy == Y_LAST) ? '0 : cy + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/life_gen_controller.sv
// life_gen_controller: Game-of-Life generation sequencer.
//   clock, reset        system clock, synchronous active-high reset
//   load, step, tick    single-cycle commands; run is a level enabling tick
//   rd_x/rd_y/rd_bank   cell read address; rd_data returns one cycle later
//   wr_en/wr_x/wr_y/wr_bank/wr_data   cell write port
//   x/y/colour/writeEn  VGA plot stream
//   busy                high whenever the sequencer is not IDLE
//   gen_count           generations since reset/load (wrapping)
//   state_dbg           current sequencer state
//
// Command handshake: load, step and (run & tick) are sampled only while the
// sequencer is IDLE, with priority load > step > run&tick. Anything arriving
// while busy is dropped; there is no request queue and no back-pressure.
module life_gen_controller
  import life_pkg::*;
#(
  parameter int COLS     = GRID_W,
  parameter int ROWS     = GRID_H,
  parameter int SEED_COL = INIT_COL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             run,
  input  logic             tick,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_bank,
  input  logic             rd_data,
  output logic             wr_en,
  output logic [X_W-1:0]   wr_x,
  output logic [Y_W-1:0]   wr_y,
  output logic             wr_bank,
  output logic             wr_data,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [2:0]       colour,
  output logic             writeEn,
  output logic             busy,
  output logic [15:0]      gen_count,
  output gen_state_e       state_dbg
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);
  localparam logic [X_W-1:0] X_SEED = X_W'(SEED_COL);

  gen_state_e     state, next_state;
  logic           front;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [3:0]     phase;       // 0..9 within one COMPUTE cell
  logic [3:0]     nbr_cnt;     // neighbours seen so far (excludes last one)
  logic           self_q;
  logic           draw_tail;   // final DRAW cycle: last plot, no read
  logic           plot_pend;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;

  logic           cell_adv;
  logic           last_cell;
  logic [X_W-1:0] nbr_x;
  logic [Y_W-1:0] nbr_y;
  logic [3:0]     n_total;
  logic           next_cell;

  life_nbr_addr #(.COLS(COLS), .ROWS(ROWS)) u_nbr (
    .cx  (cx),
    .cy  (cy),
    .idx (phase),
    .nx  (nbr_x),
    .ny  (nbr_y)
  );

  assign last_cell = (cx == X_LAST) && (cy == Y_LAST);
  // At phase 9 rd_data carries the eighth neighbour (offset +1,+1).
  assign n_total   = nbr_cnt + {3'b000, rd_data};
  assign next_cell = (n_total == 4'd3) || (self_q && (n_total == 4'd2));

  always_comb begin
    next_state = state;
    cell_adv   = 1'b0;
    rd_x       = '0;
    rd_y       = '0;
    rd_bank    = front;
    wr_en      = 1'b0;
    wr_x       = '0;
    wr_y       = '0;
    wr_bank    = front;
    wr_data    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load)             next_state = S_INIT;
        else if (step)        next_state = S_COMPUTE;
        else if (run && tick) next_state = S_COMPUTE;
      end
      S_INIT: begin
        wr_en    = 1'b1;
        wr_x     = cx;
        wr_y     = cy;
        wr_data  = (cx == X_SEED);
        cell_adv = 1'b1;
        if (last_cell) next_state = S_DRAW;
      end
      S_COMPUTE: begin
        if (phase <= 4'd8) begin
          rd_x = nbr_x;
          rd_y = nbr_y;
        end else begin
          // Always the back bank, so never the bank being read.
          wr_en    = 1'b1;
          wr_x     = cx;
          wr_y     = cy;
          wr_bank  = ~front;
          wr_data  = next_cell;
          cell_adv = 1'b1;
          if (last_cell) next_state = S_SWAP;
        end
      end
      S_SWAP: next_state = S_DRAW;
      S_DRAW: begin
        if (!draw_tail) begin
          rd_x     = cx;
          rd_y     = cy;
          cell_adv = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      front     <= 1'b0;
      gen_count <= '0;
      cx        <= '0;
      cy        <= '0;
      phase     <= '0;
      nbr_cnt   <= '0;
      self_q    <= 1'b0;
      draw_tail <= 1'b0;
      plot_pend <= 1'b0;
      plot_x    <= '0;
      plot_y    <= '0;
    end else begin
      state <= next_state;

      // Shared row-major scan counter; wraps to 0 after the last cell so
      // every pass starts at (0,0).
      if (cell_adv) begin
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end

      if (state == S_COMPUTE) begin
        phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
        // rd_data at phase k belongs to offset k-1; phase 5 is the centre.
        if (phase == 4'd0)      nbr_cnt <= '0;
        else if (phase == 4'd5) self_q  <= rd_data;
        else                    nbr_cnt <= nbr_cnt + {3'b000, rd_data};
      end else begin
        phase <= '0;
      end

      if (state == S_INIT && last_cell) gen_count <= '0;

      if (state == S_SWAP) begin
        front     <= ~front;
        gen_count <= gen_count + 16'd1;
      end

      draw_tail <= (state == S_DRAW) && (draw_tail || last_cell);
      plot_pend <= (state == S_DRAW) && !draw_tail;
      if (state == S_DRAW && !draw_tail) begin
        plot_x <= cx;
        plot_y <= cy;
      end
    end
  end

  assign writeEn   = plot_pend;
  assign x         = plot_x;
  assign y         = plot_y;
  assign colour    = (plot_pend && rd_data) ? ALIVE_COLOUR : DEAD_COLOUR;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_life_gen_controller.sv
// tb_life_gen_controller: randomized bench for life_gen_controller on a
// reduced 12x8 torus (same rules, shorter passes). A two-bank cell memory
// lives here; a reference grid computes each generation from the Life rules
// and pushes the expected VGA plot stream; a monitor pops on writeEn.
module tb_life_gen_controller;

  localparam int W        = 12;
  localparam int H        = 8;
  localparam int SEED     = 5;
  localparam int WH       = W * H;
  localparam int STEP_CYC = 11 * WH + 2;  // COMPUTE 10*WH + SWAP 1 + DRAW WH+1
  localparam int LOAD_CYC = 2 * WH + 1;   // INIT WH + DRAW WH+1

  logic        clock = 1'b0;
  logic        reset, load, step, run, tick;
  logic [7:0]  rd_x, wr_x, x;
  logic [6:0]  rd_y, wr_y, y;
  logic        rd_bank, wr_en, wr_bank, wr_data, writeEn, busy;
  logic        rd_data = 1'b0;
  logic [2:0]  colour;
  logic [15:0] gen_count;
  life_pkg::gen_state_e state_dbg;

  int          checks   = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  bit          mem[2][WH];
  bit          ref_g[WH];
  int          wr_cnt;
  int          bank_bad;
  bit          in_step = 1'b0;
  bit          exp_front;
  int          exp_gen;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  life_gen_controller #(.COLS(W), .ROWS(H), .SEED_COL(SEED)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .run       (run),
    .tick      (tick),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_bank   (rd_bank),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_bank   (wr_bank),
    .wr_data   (wr_data),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .writeEn   (writeEn),
    .busy      (busy),
    .gen_count (gen_count),
    .state_dbg (state_dbg)
  );

  function automatic int cell_idx(input logic [7:0] cx, input logic [6:0] cy);
    int v;
    v = int'(cy) * W + int'(cx);
    return (v < WH) ? v : 0;
  endfunction

  // Cell memory: registered read (old data on same-cycle collision).
  always @(posedge clock) begin
    rd_data <= mem[rd_bank][cell_idx(rd_x, rd_y)];
    if (wr_en) mem[wr_bank][cell_idx(wr_x, wr_y)] = wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (wr_en) begin
      wr_cnt++;
      if (in_step && (wr_bank == rd_bank || wr_bank != !exp_front)) bank_bad++;
    end
    if (writeEn) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d expected no plot", x, y, colour);
      end else begin
        chk("plot", {14'd0, x, y, colour}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_step();
    bit nxt[WH];
    int n;
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0)
              n += int'(ref_g[((cy + dy + H) % H) * W + (cx + dx + W) % W]);
        nxt[cy * W + cx] = (n == 3) || (ref_g[cy * W + cx] && n == 2);
      end
    ref_g = nxt;
  endtask

  task automatic push_plots();
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++)
        exp_q.push_back({8'(cx), 7'(cy), ref_g[cy * W + cx] ? 3'b111 : 3'b000});
  endtask

  task automatic clear_ref();
    for (int i = 0; i < WH; i++) ref_g[i] = 1'b0;
  endtask

  task automatic set_cell(input int cx, input int cy);
    ref_g[cy * W + cx] = 1'b1;
  endtask

  task automatic seed_bank(input int b);
    for (int i = 0; i < WH; i++) mem[b][i] = ref_g[i];
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_front = 1'b0;
    exp_gen   = 0;
  endtask

  // kind 0: load (with step in the same cycle, load must win)
  // kind 1: step; kind 2: tick with run held high by the caller
  task automatic run_op(input string name, input int kind, input bit noise, input int exp_dur);
    int dur, n1, n2, n3;
    wr_cnt   = 0;
    bank_bad = 0;
    in_step  = (kind != 0);
    n1 = $urandom_range(2, exp_dur - 20);
    n2 = $urandom_range(2, exp_dur - 20);
    n3 = $urandom_range(2, exp_dur - 20);
    @(negedge clock);
    if (kind == 0) begin load = 1'b1; step = 1'b1; end
    else if (kind == 1) step = 1'b1;
    else tick = 1'b1;
    @(negedge clock);
    load = 1'b0; step = 1'b0; tick = 1'b0;
    chk({name, "_busy_rise"}, 32'(busy), 32'd1);
    dur = 0;
    while (busy && dur < exp_dur + 50) begin
      dur++;
      if (noise) begin
        step = (dur == n1);
        load = (dur == n2);
        tick = (dur == n3);
      end
      @(negedge clock);
    end
    load = 1'b0; step = 1'b0; tick = 1'b0;
    chk({name, "_busy_cycles"}, 32'(dur), 32'(exp_dur));
    repeat (4) @(negedge clock);
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
    chk({name, "_plots_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_writes"}, 32'(wr_cnt), 32'(WH));
    if (kind != 0) chk({name, "_bank_sel"}, 32'(bank_bad), 32'd0);
    in_step = 1'b0;
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic gen_op(input string name, input int kind, input bit noise);
    ref_step();
    push_plots();
    run_op(name, kind, noise, STEP_CYC);
    exp_front = !exp_front;
    exp_gen++;
    chk({name, "_gen"}, 32'(gen_count), 32'(exp_gen));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    reset = 1'b1; load = 1'b0; step = 1'b0; run = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_wr_en",   32'(wr_en),     32'd0);
    chk("rst_writeEn", 32'(writeEn),   32'd0);
    chk("rst_gen",     32'(gen_count), 32'd0);
    chk("rst_x",       32'(x),         32'd0);
    chk("rst_y",       32'(y),         32'd0);
    chk("rst_rd_xy",   {17'd0, rd_x, rd_y}, 32'd0);
    chk("rst_wr_xy",   {17'd0, wr_x, wr_y}, 32'd0);
    chk("rst_colour",  32'(colour),    32'd0);
    reset = 1'b0;
    exp_front = 1'b0;
    exp_gen   = 0;

    // Load: column SEED alive in every row, drawn, gen_count cleared.
    clear_ref();
    for (int cy = 0; cy < H; cy++) set_cell(SEED, cy);
    push_plots();
    run_op("load", 0, 1'b1, LOAD_CYC);
    chk("load_gen", 32'(gen_count), 32'd0);
    bad = 0;
    for (int i = 0; i < WH; i++) if (mem[0][i] != ref_g[i]) bad++;
    chk("load_mem_bank0", 32'(bad), 32'd0);

    // One generation from the seeded column: three adjacent live columns.
    gen_op("load_step", 1, 1'b1);
    bad = 0;
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++)
        if (ref_g[cy * W + cx] != (cx >= SEED - 1 && cx <= SEED + 1)) bad++;
    chk("ref_three_columns", 32'(bad), 32'd0);

    // Horizontal blinker oscillates with period 2.
    do_reset();
    clear_ref();
    set_cell(3, 2); set_cell(4, 2); set_cell(5, 2);
    seed_bank(0);
    gen_op("blinker_1", 1, 1'b0);
    gen_op("blinker_2", 1, 1'b1);

    // Blinker straddling the x and y seams.
    do_reset();
    clear_ref();
    set_cell(W - 1, 0); set_cell(0, 0); set_cell(1, 0);
    seed_bank(0);
    gen_op("wrap_blinker", 1, 1'b0);

    // Random soups.
    do_reset();
    for (int i = 0; i < WH; i++) ref_g[i] = 1'($urandom_range(0, 1));
    seed_bank(0);
    for (int g = 0; g < 3; g++) gen_op("random", 1, 1'b1);

    // Reset in the middle of COMPUTE, with the front bank currently 1.
    for (int i = 0; i < WH; i++) ref_g[i] = 1'($urandom_range(0, 1));
    seed_bank(0);
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    repeat ($urandom_range(50, 400)) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy",    32'(busy),      32'd0);
    chk("abort_wr_en",   32'(wr_en),     32'd0);
    chk("abort_writeEn", 32'(writeEn),   32'd0);
    chk("abort_gen",     32'(gen_count), 32'd0);
    reset = 1'b0;
    exp_front = 1'b0;
    exp_gen   = 0;
    clear_ref();
    set_cell(7, 5); set_cell(8, 5); set_cell(9, 5); set_cell(2, 1);
    seed_bank(0);
    for (int i = 0; i < WH; i++) mem[1][i] = 1'($urandom_range(0, 1));
    gen_op("after_abort", 1, 1'b0);

    // Free-run: one generation per tick, extra ticks/pulses while busy dropped.
    run = 1'b1;
    for (int t = 0; t < 2; t++) begin
      gen_op("run_tick", 2, 1'b1);
      repeat (300) @(negedge clock);
      chk("run_idle_between", 32'(busy), 32'd0);
    end
    run = 1'b0;
    @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    chk("tick_without_run", 32'(busy), 32'd0);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
